pxs_stream_gen: RTL

Source of the 26-bit pixel stream consumed by every Pxs overlay stage. Generates horizontal/vertical counters, sync levels and the active-video flag for a configurable VGA mode, packs them with a background colour into the stream word, and feeds the head of the overlay chain. Also emits frame and line strobes for blocks that update per frame or per line.

---
 rtl/pxs_stream_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/pxs_stream_gen.sv
// rtl/pxs_stream_gen.sv - VGA-timed 26-bit pixel stream source feeding the Pxs overlay chain
// Optional `PXS_TESTPATTERN_EN replaces the active-area colour with 8 vertical colour bars.
module pxs_stream_gen #(
  parameter int         hact     = 640,
  parameter int         hfp      = 16,
  parameter int         hsw      = 96,
  parameter int         hbp      = 48,
  parameter int         vact     = 480,
  parameter int         vfp      = 10,
  parameter int         vsw      = 2,
  parameter int         vbp      = 33,
  parameter logic       hs_pol   = 1'b0,
  parameter logic       vs_pol   = 1'b0,
  parameter logic [2:0] color_bg = 3'b000
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        en,
  output logic [25:0] RGBStr_o,
  output logic        frame_o,
  output logic        line_o
);

  localparam int htot = hact + hfp + hsw + hbp;
  localparam int vtot = vact + vfp + vsw + vbp;

  localparam logic [10:0] H_ACT = 11'(hact);
  localparam logic [10:0] H_SS  = 11'(hact + hfp);
  localparam logic [10:0] H_SE  = 11'(hact + hfp + hsw);
  localparam logic [10:0] V_ACT = 11'(vact);
  localparam logic [10:0] V_SS  = 11'(vact + vfp);
  localparam logic [10:0] V_SE  = 11'(vact + vfp + vsw);
  localparam logic [9:0]  H_LAST = 10'(htot - 1);
  localparam logic [9:0]  V_LAST = 10'(vtot - 1);

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [10:0] hc11;
  logic [10:0] vc11;
  logic        act;
  logic        hs;
  logic        vs;
  logic [2:0]  rgb_src;
  logic [2:0]  rgb;
  logic [25:0] word;

  assign hc11 = {1'b0, hc};
  assign vc11 = {1'b0, vc};

`ifdef PXS_TESTPATTERN_EN
  localparam logic [9:0] BAR_LAST = 10'(hact / 8 - 1);

  logic [2:0] bar_idx;
  logic [9:0] bar_cnt;

  // Bar index follows hc incrementally; the last bar simply keeps counting.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      bar_idx <= 3'd0;
      bar_cnt <= 10'd0;
    end else if (en) begin
      if (hc == H_LAST) begin
        bar_idx <= 3'd0;
        bar_cnt <= 10'd0;
      end else if (bar_idx != 3'd7 && bar_cnt == BAR_LAST) begin
        bar_idx <= bar_idx + 3'd1;
        bar_cnt <= 10'd0;
      end else begin
        bar_cnt <= bar_cnt + 10'd1;
      end
    end
  end

  assign rgb_src = bar_idx;
`else
  assign rgb_src = color_bg;
`endif

  always_comb begin
    act  = (hc11 < H_ACT) && (vc11 < V_ACT);
    hs   = (hc11 >= H_SS && hc11 < H_SE) ? hs_pol : ~hs_pol;
    vs   = (vc11 >= V_SS && vc11 < V_SE) ? vs_pol : ~vs_pol;
    rgb  = act ? rgb_src : 3'b000;
    word = {rgb, hc, vc, hs, vs, act};
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      hc       <= 10'd0;
      vc       <= 10'd0;
      RGBStr_o <= {23'd0, ~hs_pol, ~vs_pol, 1'b0};
      frame_o  <= 1'b0;
      line_o   <= 1'b0;
    end else if (en) begin
      RGBStr_o <= word;
      frame_o  <= (hc == 10'd0) && (vc == 10'd0);
      line_o   <= (hc == 10'd0);
      if (hc == H_LAST) begin
        hc <= 10'd0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

endmodule
